// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator datapath:
//   - sig codes carried from the input sequencer to the output-processing stage
//   - command mode encoding (ACC / CAT; codes 2 and 3 are reserved)
//   - input sequencer state encoding
//   - mode_is_legal(): true for the modes the sequencer can execute
// -----------------------------------------------------------------------------
package acc_pkg;

    localparam logic [2:0] SIG_NOP   = 3'b000;
    localparam logic [2:0] SIG_ACC   = 3'b001;
    localparam logic [2:0] SIG_OUT   = 3'b010;
    localparam logic [2:0] SIG_CAT_S = 3'b011;
    localparam logic [2:0] SIG_CAT_E = 3'b100;

    typedef enum logic [1:0] {
        MODE_ACC = 2'd0,
        MODE_CAT = 2'd1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    // Only codes 0 and 1 are defined; the upper bit marks the reserved pair.
    function automatic logic mode_is_legal(input logic [1:0] mode);
        return (mode[1] == 1'b0);
    endfunction

endpackage

// File: rtl/acc_beat_cnt.sv
// -----------------------------------------------------------------------------
// acc_beat_cnt
// Loadable down-counter of remaining data beats.
//   clk, rst     : clock, asynchronous active-low reset (count -> 0)
//   clr_i        : force count to 0 (highest priority)
//   load_i       : load load_val_i
//   dec_i        : decrement by one; saturates at 0, never wraps
//   cnt_o        : remaining beats
//   last_o       : remaining == 1, i.e. the next beat is the final one
// -----------------------------------------------------------------------------
module acc_beat_cnt #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [LEN_W-1:0] cnt_o,
    output logic             last_o
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/acc_in_seq.sv
// -----------------------------------------------------------------------------
// acc_in_seq
// Input-side sequencer for the accumulator datapath. Accepts a (mode, length)
// command, pulls that many words from an upstream valid/ready stream and
// drives the registered control stream of the output-processing stage.
//   clk, rst                    : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake (ready only while idle)
//   cmd_mode, cmd_len           : 0=ACC, 1=CAT; number of data beats
//   abort                       : cancel the command in CLEAR/STREAM
//   in_valid/in_ready, in_data  : upstream word stream (ready only in STREAM)
//   data_o, data_valid_o        : forwarded word and its one-cycle strobe
//   sig_o                       : control code for the output stage
//   clear_reg_o, is_stop_o      : clear accumulator / last-result strobe
//   busy, err_o                 : command in progress / rejected command pulse
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module acc_in_seq
    import acc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [2:0]        sig_o,
    output logic              clear_reg_o,
    output logic              is_stop_o,
    output logic              busy,
    output logic              err_o
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dv_q, dv_d;
    logic [2:0]        sig_q, sig_d;
    logic              clr_q, clr_d;
    logic              stop_q, stop_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic              cmd_ok;
    logic              abort_hit;
    logic              beat;
    logic [LEN_W-1:0]  cnt;
    logic              cnt_last;

    always_comb begin
        accept    = cmd_valid && cmd_ready_q;
        cmd_ok    = (cmd_len != '0) && mode_is_legal(cmd_mode);
        abort_hit = abort && ((state_q == ST_CLEAR) || (state_q == ST_STREAM));
        // in_ready_q is high exactly while in STREAM; abort wins over a beat.
        beat      = in_valid && in_ready_q && !abort;
    end

    acc_beat_cnt #(
        .LEN_W(LEN_W)
    ) u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (abort_hit),
        .load_i    (accept && cmd_ok),
        .load_val_i(cmd_len),
        .dec_i     (beat),
        .cnt_o     (cnt),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        sig_d   = SIG_NOP;
        clr_d   = 1'b0;
        stop_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_ok) begin
                        state_d = ST_CLEAR;
                        mode_d  = mode_e'(cmd_mode);
                        len_d   = cmd_len;
                        clr_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (abort_hit) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort_hit) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (beat) begin
                    data_d = in_data;
                    dv_d   = 1'b1;
                    if (mode_q == MODE_ACC) begin
                        sig_d = SIG_ACC;
                    end else if (cnt_last) begin
                        // A single-beat CAT is reported as its end only.
                        sig_d = SIG_CAT_E;
                    end else if (cnt == len_q) begin
                        sig_d = SIG_CAT_S;
                    end
                    if (cnt_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The cycle spent here shows the last beat; the stop marker
                // follows it while the state is already back in IDLE.
                state_d = ST_IDLE;
                sig_d   = SIG_OUT;
                stop_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The stop-marker cycle still counts as busy and blocks new commands.
        busy_d      = (state_d != ST_IDLE) || (state_q == ST_FLUSH);
        cmd_ready_d = (state_d == ST_IDLE) && (state_q != ST_FLUSH);
        in_ready_d  = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ACC;
            len_q       <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            sig_q       <= SIG_NOP;
            clr_q       <= 1'b0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            sig_q       <= sig_d;
            clr_q       <= clr_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign in_ready     = in_ready_q;
    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign sig_o        = sig_q;
    assign clear_reg_o  = clr_q;
    assign is_stop_o    = stop_q;
    assign busy         = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_acc_in_seq.sv
// -----------------------------------------------------------------------------
// tb_acc_in_seq
// Bench for acc_in_seq: directed scenarios plus a randomized phase, checked
// every cycle against a visible-timeline model, with literal expectations on
// the strobe log of each directed scenario.
// -----------------------------------------------------------------------------
module tb_acc_in_seq;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    // Phases of the externally visible timeline of one command.
    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_STREAM = 2;
    localparam int P_LAST   = 3;  // last word on data_o
    localparam int P_STOP   = 4;  // stop marker on sig_o/is_stop_o

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_mode  = 2'd0;
    logic [LEN_W-1:0]  cmd_len   = '0;
    logic              abort     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              cmd_ready;
    logic              in_ready;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic [2:0]        sig_o;
    logic              clear_reg_o;
    logic              is_stop_o;
    logic              busy;
    logic              err_o;

    always #5 clk = ~clk;

    acc_in_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_len     (cmd_len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .sig_o       (sig_o),
        .clear_reg_o (clear_reg_o),
        .is_stop_o   (is_stop_o),
        .busy        (busy),
        .err_o       (err_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ph     = P_IDLE;
    bit          rdy_ok = 1'b0;
    int          len_l  = 0;
    int          idx    = 0;
    int          n_txn  = 0;
    logic [1:0]  md_l   = 2'd0;
    bit          m_hs   = 1'b0;
    logic [31:0] e_data = '0;
    logic        e_dv   = 1'b0;
    logic [2:0]  e_sig  = 3'b000;
    logic        e_clr  = 1'b0;
    logic        e_stop = 1'b0;
    logic        e_err  = 1'b0;

    task automatic model_reset();
        ph = P_IDLE; rdy_ok = 1'b0; m_hs = 1'b0; idx = 0;
        e_data = '0; e_dv = 1'b0; e_sig = 3'b000;
        e_clr = 1'b0; e_stop = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step();
        bit cr;
        cr     = (ph == P_IDLE) && rdy_ok;
        rdy_ok = 1'b1;
        m_hs   = 1'b0;
        e_dv = 1'b0; e_sig = 3'b000; e_clr = 1'b0; e_stop = 1'b0; e_err = 1'b0;
        case (ph)
            P_IDLE: if (cmd_valid && cr) begin
                if (cmd_len == 0 || cmd_mode > 2'd1) begin
                    e_err = 1'b1;
                    n_txn++;
                    $display("txn %0d: rejected mode=%0d len=%0d", n_txn, cmd_mode, cmd_len);
                end else begin
                    ph = P_CLEAR; e_clr = 1'b1;
                    len_l = int'(cmd_len); md_l = cmd_mode; idx = 0;
                end
            end
            P_CLEAR, P_STREAM: begin
                if (abort) begin
                    ph = P_IDLE; e_clr = 1'b1;
                    n_txn++;
                    $display("txn %0d: aborted after %0d of %0d beats", n_txn, idx, len_l);
                end else if (ph == P_CLEAR) begin
                    ph = P_STREAM;
                end else if (in_valid) begin
                    m_hs = 1'b1; e_dv = 1'b1; e_data = in_data;
                    if (md_l == 2'd0)          e_sig = 3'b001;
                    else if (idx == len_l - 1) e_sig = 3'b100;
                    else if (idx == 0)         e_sig = 3'b011;
                    else                       e_sig = 3'b000;
                    idx++;
                    if (idx == len_l) ph = P_LAST;
                end
            end
            P_LAST: begin
                ph = P_STOP; e_sig = 3'b010; e_stop = 1'b1;
                n_txn++;
                $display("txn %0d: completed mode=%0d len=%0d", n_txn, md_l, len_l);
            end
            default: ph = P_IDLE;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [34:0] log_q[$];
    logic [34:0] exp_log[$];
    int n_clr = 0, n_stop = 0, n_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("cmd_ready", 64'(cmd_ready), 64'((ph == P_IDLE) && rdy_ok));
            chk("in_ready",  64'(in_ready),  64'(ph == P_STREAM));
            chk("busy",      64'(busy),      64'(ph != P_IDLE));
            chk("data_o",    64'(data_o),    64'(e_data));
            chk("data_valid_o", 64'(data_valid_o), 64'(e_dv));
            chk("sig_o",     64'(sig_o),     64'(e_sig));
            chk("clear_reg_o", 64'(clear_reg_o), 64'(e_clr));
            chk("is_stop_o", 64'(is_stop_o), 64'(e_stop));
            chk("err_o",     64'(err_o),     64'(e_err));
            if (data_valid_o === 1'b1) log_q.push_back({sig_o, data_o});
            if (clear_reg_o === 1'b1) n_clr++;
            if (is_stop_o === 1'b1)   n_stop++;
            if (err_o === 1'b1)       n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] words[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [1:0] md, input int ln);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk("issue_cmd_ready_seen", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_mode = md; cmd_len = LEN_W'(ln);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Offer words[] upstream; optional gap before word gap_at, abort when
    // abort_at words are done, or stop offering after stop_at words.
    task automatic feed(input int gap_at, input int gap_len, input int abort_at, input int stop_at);
        int i, gap, k;
        i = 0; gap = gap_len; k = 0;
        while (i < words.size() && i != stop_at && k < 100) begin
            in_data = words[i];
            if (i == abort_at) begin
                in_valid = 1'b1; abort = 1'b1;
                tick();
                abort = 1'b0; in_valid = 1'b0;
                return;
            end
            if (i == gap_at && gap > 0) begin
                in_valid = 1'b0; gap--;
            end else begin
                in_valid = 1'b1;
            end
            tick();
            k++;
            if (m_hs) i++;
        end
        in_valid = 1'b0;
        chk("feed_within_budget", 64'(k < 100), 64'd1);
    endtask

    task automatic chk_log(input string name);
        int n;
        chk({name, "_count"}, 64'(log_q.size()), 64'(exp_log.size()));
        n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
        for (int i = 0; i < n; i++) chk({name, "_entry"}, 64'(log_q[i]), 64'(exp_log[i]));
    endtask

    // ---------------- main sequence ----------------
    int s_clr, s_stop, s_err;

    initial begin
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);

        // ACC len=3, back-to-back words 5,7,9
        log_q.delete(); s_clr = n_clr; s_stop = n_stop;
        issue(2'd0, 3);
        words = '{32'd5, 32'd7, 32'd9};
        feed(-1, 0, -1, -1);
        idle(4);
        exp_log = '{{3'b001, 32'd5}, {3'b001, 32'd7}, {3'b001, 32'd9}};
        chk_log("acc3");
        chk("acc3_clear", 64'(n_clr - s_clr), 64'd1);
        chk("acc3_stop", 64'(n_stop - s_stop), 64'd1);

        // CAT len=4 with a 2-cycle upstream gap between B and C
        log_q.delete(); s_stop = n_stop;
        issue(2'd1, 4);
        words = '{32'hA, 32'hB, 32'hC, 32'hD};
        feed(2, 2, -1, -1);
        idle(4);
        exp_log = '{{3'b011, 32'hA}, {3'b000, 32'hB}, {3'b000, 32'hC}, {3'b100, 32'hD}};
        chk_log("cat4");
        chk("cat4_stop", 64'(n_stop - s_stop), 64'd1);

        // CAT len=1
        log_q.delete(); s_stop = n_stop;
        issue(2'd1, 1);
        words = '{32'hFFFF_FFFF};
        feed(-1, 0, -1, -1);
        idle(4);
        exp_log = '{{3'b100, 32'hFFFF_FFFF}};
        chk_log("cat1");
        chk("cat1_stop", 64'(n_stop - s_stop), 64'd1);

        // Rejected commands
        log_q.delete(); s_err = n_err; s_clr = n_clr;
        issue(2'd0, 0);
        issue(2'd3, 2);
        idle(3);
        chk("reject_err", 64'(n_err - s_err), 64'd2);
        chk("reject_clear", 64'(n_clr - s_clr), 64'd0);
        chk("reject_strobes", 64'(log_q.size()), 64'd0);

        // ACC len=5 aborted after two beats, with a beat offered alongside
        log_q.delete(); s_clr = n_clr; s_stop = n_stop;
        issue(2'd0, 5);
        words = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
        feed(-1, 0, 2, -1);
        idle(1);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        idle(2);
        exp_log = '{{3'b001, 32'd11}, {3'b001, 32'd22}};
        chk_log("abort");
        chk("abort_clear", 64'(n_clr - s_clr), 64'd2);
        chk("abort_stop", 64'(n_stop - s_stop), 64'd0);

        // Reset mid-STREAM, then a fresh command
        issue(2'd0, 8);
        words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        feed(-1, 0, -1, 3);
        rst = 1'b0;
        #1;
        chk("rst_outputs_zero",
            64'({data_o, data_valid_o, sig_o, clear_reg_o, is_stop_o, busy, err_o, cmd_ready, in_ready}),
            64'd0);
        idle(2);
        rst = 1'b1;
        idle(2);
        log_q.delete(); s_stop = n_stop;
        issue(2'd0, 1);
        words = '{32'h1234};
        feed(-1, 0, -1, -1);
        idle(4);
        exp_log = '{{3'b001, 32'h1234}};
        chk_log("post_rst");
        chk("post_rst_stop", 64'(n_stop - s_stop), 64'd1);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 800; c++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_mode  = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            cmd_len   = LEN_W'($urandom_range(0, 5));
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            abort     = ($urandom_range(0, 29) == 0);
            tick();
        end
        cmd_valid = 1'b0; in_valid = 1'b0; abort = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
